// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencing controller: state encoding,
// tap count, RAM address stride and the AXI-lite register map.
package fir_pkg;

    localparam int TAP_NUM     = 11;
    localparam int ADDR_STRIDE = 4;
    localparam int IDX_W       = 4;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_IN,
        CALC,
        OUT,
        DONE
    } fir_state_e;

    typedef enum logic [11:0] {
        AP_CTRL  = 12'h000,
        DATA_LEN = 12'h010,
        TAP_BASE = 12'h020
    } fir_reg_e;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Stream bundle of fir_seq_ctrl: ss_* brings samples in, sm_* hands results out.
// master is the surrounding stream environment, slave is the sequencer itself.
interface fir_seq_ctrl_if #(
    parameter int pDATA_WIDTH = 32
);

    logic                   ss_tvalid;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   ss_tlast;
    logic                   ss_tready;

    logic                   sm_tready;
    logic                   sm_tvalid;
    logic                   sm_tlast;

    modport master (
        output ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        input  ss_tready, sm_tvalid, sm_tlast
    );

    modport slave (
        input  ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        output ss_tready, sm_tvalid, sm_tlast
    );

endinterface

// File: rtl/fir_ring_idx.sv
// Mod-DEPTH circular index helper: write-pointer advance and the
// (ptr - k) wrap used to walk the data buffer newest-to-oldest.
module fir_ring_idx
    import fir_pkg::*;
#(
    parameter int DEPTH = TAP_NUM
) (
    input  idx_t ptr,
    input  idx_t k,
    output idx_t ptr_next,
    output idx_t rd_idx
);

    // ptr + DEPTH may exceed the index width; the modular arithmetic still
    // lands on the right slot because the final result is below DEPTH.
    always_comb begin
        ptr_next = (ptr == idx_t'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        rd_idx   = (ptr >= k) ? ptr - k : ptr + idx_t'(DEPTH) - k;
    end

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencing controller for the 11-tap FIR: clears the data RAM, takes samples,
// walks tap/data RAMs for the MAC and hands results out. Macro: FIR_TLAST_CHECK_EN.
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = TAP_NUM
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,

    input  logic                   ap_start,
    input  logic                   done_rd,
    input  logic [31:0]            data_length,
    output logic                   ap_done,
    output logic                   ap_idle,

    fir_seq_ctrl_if.slave          axis,

    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    output logic                   mac_clr,
    output logic                   mac_en,
    output logic                   err
);

    localparam idx_t LAST_IDX  = idx_t'(Tape_Num - 1);
    // One extra CALC step lets the last read drain through the RAM latency.
    localparam idx_t DRAIN_IDX = idx_t'(Tape_Num);

    fir_state_e  state, state_nxt;
    idx_t        ptr, ptr_next, rd_idx, k;
    logic [31:0] cnt, len_r;
    logic        start_acc, last_sample;

    function automatic logic [pADDR_WIDTH-1:0] to_addr(input idx_t i);
        return pADDR_WIDTH'(i) * pADDR_WIDTH'(ADDR_STRIDE);
    endfunction

    fir_ring_idx #(
        .DEPTH (Tape_Num)
    ) u_ring_idx (
        .ptr      (ptr),
        .k        (k),
        .ptr_next (ptr_next),
        .rd_idx   (rd_idx)
    );

    assign start_acc   = (state == IDLE) && ap_start;
    assign last_sample = (cnt == len_r - 32'd1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            k       <= '0;
            cnt     <= '0;
            len_r   <= '0;
            ap_done <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        ptr   <= '0;
                        k     <= '0;
                        cnt   <= '0;
                        len_r <= data_length;
                    end
                end
                CLEAR:   k <= (k == LAST_IDX) ? '0 : k + 1'b1;
                CALC:    k <= (k == DRAIN_IDX) ? '0 : k + 1'b1;
                OUT: begin
                    if (axis.sm_tready) begin
                        cnt <= cnt + 32'd1;
                        ptr <= ptr_next;
                    end
                end
                default: ;
            endcase

            // Completion wins over any clear in the same cycle so a run is never lost.
            if (state == DONE) begin
                ap_done <= 1'b1;
            end else if (start_acc || done_rd) begin
                ap_done <= 1'b0;
            end
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt      = state;
        ap_idle        = 1'b0;
        axis.ss_tready = 1'b0;
        axis.sm_tvalid = 1'b0;
        axis.sm_tlast  = 1'b0;
        tap_EN         = 1'b0;
        tap_A          = '0;
        data_EN        = 1'b0;
        data_WE        = 4'h0;
        data_A         = '0;
        data_Di        = '0;
        mac_en         = 1'b0;
        mac_clr        = 1'b0;

        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_nxt = CLEAR;
            end
            CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = to_addr(k);
                if (k == LAST_IDX) state_nxt = (len_r != 32'd0) ? WAIT_IN : DONE;
            end
            WAIT_IN: begin
                axis.ss_tready = 1'b1;
                if (axis.ss_tvalid) begin
                    data_EN   = 1'b1;
                    data_WE   = 4'hF;
                    data_A    = to_addr(ptr);
                    data_Di   = axis.ss_tdata;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (k != DRAIN_IDX) begin
                    tap_EN  = 1'b1;
                    data_EN = 1'b1;
                    tap_A   = to_addr(k);
                    data_A  = to_addr(rd_idx);
                end
                // The product of read k is on the RAM outputs one step later.
                mac_en  = (k != '0);
                mac_clr = (k == idx_t'(1));
                if (k == DRAIN_IDX) state_nxt = OUT;
            end
            OUT: begin
                axis.sm_tvalid = 1'b1;
                axis.sm_tlast  = last_sample;
                if (axis.sm_tready) state_nxt = last_sample ? DONE : WAIT_IN;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FIR_TLAST_CHECK_EN
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            err <= 1'b0;
        end else if (start_acc) begin
            err <= 1'b0;
        end else if (state == WAIT_IN && axis.ss_tvalid && (axis.ss_tlast != last_sample)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_tlast;
    assign unused_tlast = axis.ss_tlast;
    assign err          = 1'b0;
`endif

endmodule
